// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register carrying a control and a data bundle.
// SKID=1 gives a 2-entry skid buffer with a registered in_ready.
// SKID=0 gives a single register with a combinational in_ready.
// Control is masked to zero whenever no valid item is presented, so a
// bubble cannot cause a write further down the pipe.
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 127,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Head-of-stage entry, whichever variant is built.
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    logic accept;
    logic emit;

    assign accept    = in_valid & in_ready;
    assign emit      = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Bubble masking: every control bit is gated by the valid flag.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = main_ctrl[gi] & main_valid;
        end
    endgenerate

    generate
        if (SKID) begin : g_skid
            state_t            state_reg;
            state_t            state_next;
            logic              in_ready_reg;
            logic              load_main_in;
            logic              load_main_skid;
            logic              load_skid;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic [DATA_W-1:0] main_data_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;
            logic [DATA_W-1:0] skid_data_reg;

            // State register; in_ready is registered from the next state so
            // upstream never sees a combinational path from out_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg    <= ST_EMPTY;
                    in_ready_reg <= 1'b1;
                end else begin
                    state_reg    <= state_next;
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end

            // Next-state and datapath load selects; flush overrides everything.
            always_comb begin
                state_next     = state_reg;
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                if (flush) begin
                    state_next = ST_EMPTY;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (accept) begin
                                state_next   = ST_ONE;
                                load_main_in = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (accept && emit) begin
                                load_main_in = 1'b1;
                            end else if (accept) begin
                                state_next = ST_FULL;
                                load_skid  = 1'b1;
                            end else if (emit) begin
                                state_next = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (emit) begin
                                state_next     = ST_ONE;
                                load_main_skid = 1'b1;
                            end
                        end
                        default: state_next = ST_EMPTY;
                    endcase
                end
            end

            // Main entry: loads from the input or is refilled from the skid entry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_ctrl_reg <= '0;
                    main_data_reg <= '0;
                end else if (load_main_in) begin
                    main_ctrl_reg <= in_ctrl;
                    main_data_reg <= in_data;
                end else if (load_main_skid) begin
                    main_ctrl_reg <= skid_ctrl_reg;
                    main_data_reg <= skid_data_reg;
                end
            end

            // Skid entry catches the item accepted while the output is stalled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_ctrl_reg <= '0;
                    skid_data_reg <= '0;
                end else if (load_skid) begin
                    skid_ctrl_reg <= in_ctrl;
                    skid_data_reg <= in_data;
                end
            end

            // Occupancy follows directly from the state.
            always_comb begin
                occupancy = 2'd0;
                case (state_reg)
                    ST_ONE:  occupancy = 2'd1;
                    ST_FULL: occupancy = 2'd2;
                    default: occupancy = 2'd0;
                endcase
            end

            assign in_ready   = in_ready_reg;
            assign main_valid = (state_reg != ST_EMPTY);
            assign main_ctrl  = main_ctrl_reg;
            assign main_data  = main_data_reg;
        end else begin : g_single
            logic              main_valid_reg;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic [DATA_W-1:0] main_data_reg;

            // Valid flag: set on accept, cleared on emit-only or flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid_reg <= 1'b0;
                end else if (flush) begin
                    main_valid_reg <= 1'b0;
                end else if (accept) begin
                    main_valid_reg <= 1'b1;
                end else if (emit) begin
                    main_valid_reg <= 1'b0;
                end
            end

            // Payload register loads only on a non-flushed accept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_ctrl_reg <= '0;
                    main_data_reg <= '0;
                end else if (accept && !flush) begin
                    main_ctrl_reg <= in_ctrl;
                    main_data_reg <= in_data;
                end
            end

            assign in_ready   = !main_valid_reg | out_ready;
            assign main_valid = main_valid_reg;
            assign main_ctrl  = main_ctrl_reg;
            assign main_data  = main_data_reg;
            assign occupancy  = {1'b0, main_valid_reg};
        end
    endgenerate

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline latch. It carries a control bundle and a data bundle between two pipeline stages.
- Adds a valid/ready handshake, stall back-pressure, synchronous flush with bubble insertion, and an optional 2-entry skid buffer.
- With SKID=1, in_ready is fully registered. This breaks the combinational ready path between stages.
- One instance per stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- CTRL_W, 9: width of the control bundle (RegDst, AluOp[1:0], AluSrc, Branch, MemRead, MemWrite, RegWrite, MemToReg).
- DATA_W, 127: width of the data bundle (pc4 32 + rd1 32 + rd2 32 + imm 16 + rs/rt/rd 15).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream sees a valid instruction.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control to next stage; forced 0 when out_valid=0.
- out_data  out  DATA_W  data to next stage.
- occupancy  out  2  entries held: 0..1 when SKID=0, 0..2 when SKID=1.

Behaviour:
- Reset (rst_n=0, asynchronous): all valid flags, out_ctrl, out_data and occupancy go to 0.
  - in_ready = 1 during reset and in the cycle after release.
- Transfers:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Both are evaluated at the rising edge.
- Latency: an accepted item appears on out_* exactly 1 cycle after acceptance when the stage was empty or emitting. Throughput is 1 item/cycle with no stalls.
- Ordering: strict FIFO; no item is duplicated or dropped except by flush.
- Bubble rule: out_ctrl = 0 whenever out_valid = 0, so a bubble never writes registers or memory.
  - out_data holds its last value when out_valid = 0. It is not zeroed, except by reset.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept, the main register loads the input.
  - On emit without accept, out_valid clears.
- SKID=1: states EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2, main + skid valid).
  - in_ready = (state != FULL), registered.
  - EMPTY + accept -> ONE.
  - ONE + accept + emit -> ONE; main reloads from input.
  - ONE + accept + !emit -> FULL; input goes to skid, main holds.
  - ONE + !accept + emit -> EMPTY.
  - FULL + emit -> ONE; skid moves to main, skid cleared. No accept is possible in FULL.
  - FULL + !emit -> FULL; all held.
- Flush:
  - Takes priority over every transfer.
  - Next state is EMPTY, occupancy 0, out_valid 0, out_ctrl 0.
  - An in_valid item presented in the flush cycle is discarded, even if in_ready = 1.
  - An emit in the flush cycle still counts downstream; downstream owns its own kill.
- Reset mid-stall: state returns to EMPTY immediately; held items are lost.
- in_ctrl/in_data are sampled only on accept and ignored otherwise.

Test Plan:
- Reset then stream: rst_n low 3 cycles, then in_valid=1 with in_ctrl=9'h1A5, in_data=1..5 on successive cycles, out_ready=1 -> out_data 1..5 on cycles 1..5 after the first accept; out_ctrl=9'h1A5; occupancy=1 throughout.
- Stall/skid (SKID=1):
  - Stream 10,11,12 with out_ready=0 from the cycle 10 appears -> 11 captured in skid, occupancy=2, in_ready=0, 12 held upstream.
  - Release out_ready -> outputs 10,11,12 in order with no gap.
- Bubble: in_valid=0 for one cycle mid-stream with in_ctrl=9'h1FF driven -> out_valid=0 and out_ctrl=0 for exactly one cycle; out_data holds the previous value.
- Flush in FULL: occupancy=2 (items 20,21), flush=1 with in_valid=1, in_data=22 -> next cycle occupancy=0, out_valid=0, in_ready=1; item 22 never appears at the output.
- SKID=0 combinational ready: out_valid=1, out_ready toggles 0/1 each cycle -> in_ready mirrors out_ready in the same cycle; output sequence is intact and alternates hold/advance.
- Async reset mid-stall: occupancy=2, assert rst_n=0 between clock edges -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0 before the next edge.
